// File: rtl/spsram_bank_arb_pkg.sv
// Shared defaults and helpers for the banked single-port SRAM arbiter.
// Helpers work on a fixed 32-wide vector; callers size-cast the result.
package spsram_pkg;

  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned DEPTH_DEF = 1024;
  localparam int unsigned NB_DEF    = 4;
  localparam int unsigned NR_DEF    = 2;
  localparam int unsigned SEL_MAX   = 32;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } pick_t;

  function automatic logic [SEL_MAX-1:0] bank_onehot(input logic [31:0] idx);
    return SEL_MAX'(1) << idx;
  endfunction

  // First set bit of valid at or after ptr, wrapping modulo n (ptr < n <= SEL_MAX).
  function automatic pick_t rr_pick(input logic [SEL_MAX-1:0] valid,
                                    input logic [31:0] ptr,
                                    input logic [31:0] n);
    pick_t       p;
    logic [31:0] j;
    p = '0;
    for (int k = 0; k < SEL_MAX; k++) begin
      j = ptr + 32'(k);
      if (j >= n) j = j - n;
      if ((32'(k) < n) && !p.found && valid[j[4:0]]) begin
        p.found = 1'b1;
        p.idx   = j;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/spsram_bank_arb_if.sv
// Requester + banked-SRAM bus of the arbiter; slave is the arbiter side.
// No response backpressure: rsp_valid must be taken in the cycle it is shown.
interface spsram_bank_arb_if
  import spsram_pkg::*;
#(
  parameter int NR    = NR_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NB    = NB_DEF
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(NB);
  localparam int RW = BW + AW;

  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_we;
  logic [NR*RW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_din;
  logic [NB-1:0]    mem_bs;
  logic             mem_we;
  logic [NB*DW-1:0] mem_dout;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_din, mem_bs, mem_we
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_din, mem_bs, mem_we
  );

endinterface

// File: rtl/spsram_bank_arb_rr_arbiter.sv
// Round-robin picker: combinational one-hot grant, search starts at r_ptr.
// Zero latency; r_ptr moves past the winner only when advance is high.
module rr_arbiter
  import spsram_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] r_ptr;
  pick_t         w_pick;

  assign w_pick  = rr_pick(SEL_MAX'(req), 32'(r_ptr), 32'(N));
  assign gnt_idx = IW'(w_pick.idx);
  assign gnt     = w_pick.found ? (N'(1) << w_pick.idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/spsram_bank_arb.sv
// Shares one banked single-port SRAM among NR requesters, one access per cycle.
// Read data returns one cycle after the grant, tagged one-hot; no response backpressure.
module spsram_bank_arb
  import spsram_pkg::*;
#(
  parameter  int NR    = NR_DEF,
  parameter  int DW    = DW_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int NB    = NB_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int BW    = $clog2(NB),
  localparam int RW    = BW + AW,
  localparam int IW    = $clog2(NR)
) (
  input logic              clk,
  input logic              rst,
  spsram_bank_arb_if.slave bus
);

  logic [NR-1:0] w_gnt;
  logic [IW-1:0] w_gidx;
  logic          w_any;
  logic          w_rd;
  logic [RW-1:0] w_addr;
  logic [BW-1:0] w_bank;

  logic          r_rsp_live;
  logic [IW-1:0] r_rsp_id;
  logic [BW-1:0] r_rsp_bank;

  rr_arbiter #(.N(NR)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .advance (w_any),
    .gnt     (w_gnt),
    .gnt_idx (w_gidx)
  );

  // With no grant w_gidx is 0, so address/data simply mirror requester 0.
  assign w_any  = |w_gnt;
  assign w_addr = bus.req_addr[w_gidx*RW +: RW];
  assign w_bank = w_addr[RW-1:AW];
  assign w_rd   = w_any & ~bus.req_we[w_gidx];

  assign bus.req_ready = w_gnt;
  assign bus.mem_addr  = w_addr[AW-1:0];
  assign bus.mem_din   = bus.req_wdata[w_gidx*DW +: DW];
  assign bus.mem_bs    = w_any ? NB'(bank_onehot(32'(w_bank))) : '0;
  assign bus.mem_we    = w_any & bus.req_we[w_gidx];

  assign bus.rsp_valid = r_rsp_live ? (NR'(1) << r_rsp_id) : '0;
  assign bus.rsp_rdata = bus.mem_dout[r_rsp_bank*DW +: DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_live <= 1'b0;
      r_rsp_id   <= '0;
      r_rsp_bank <= '0;
    end else begin
      r_rsp_live <= w_rd;
      if (w_rd) begin
        r_rsp_id   <= w_gidx;
        r_rsp_bank <= w_bank;
      end
    end
  end

endmodule
